// File: rtl/if_stage_pipe.sv
// if_stage_pipe: fetch PC, word-addressed imem with program-load port, and IF/ID register with freeze/branch flush
module if_stage_pipe #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] PC_RESET   = 32'h0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          freeze,
  input  logic                          br_taken,
  input  logic [31:0]                   br_target,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   pc,
  output logic [31:0]                   id_pc_plus4,
  output logic [31:0]                   id_instr,
  output logic                          id_valid,
  output logic [31:0]                   fetch_count
);
  localparam int AW = $clog2(IMEM_DEPTH);
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] pc_plus4;
  logic [31:0] fetch_word;
  logic        in_range;
  assign pc_plus4   = pc + 32'd4;
  assign in_range   = (pc >> (AW + 2)) == 32'd0;
  assign fetch_word = in_range ? imem[pc[AW+1:2]] : 32'h0;
  always_ff @(posedge clk)
    if (imem_we && !rst) imem[imem_waddr] <= imem_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= PC_RESET;
      id_instr    <= 32'h0;
      id_pc_plus4 <= 32'h0;
      id_valid    <= 1'b0;
      fetch_count <= 32'h0;
    end else if (br_taken) begin
      pc          <= br_target;
      id_instr    <= 32'h0;
      id_pc_plus4 <= 32'h0;
      id_valid    <= 1'b0;
    end else if (!freeze) begin
      pc          <= pc_plus4;
      id_instr    <= fetch_word;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_if_stage_pipe.sv
// tb_if_stage_pipe: directed checks of fetch, freeze, branch flush, out-of-range, wrap, reset and write collision
module tb_if_stage_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_waddr = 8'h0;
  logic [31:0] imem_wdata = 32'h0;
  logic [31:0] pc, id_pc_plus4, id_instr, fetch_count;
  logic        id_valid;
  logic [31:0] em [16];
  int n_checks = 0;
  int n_fail = 0;
  if_stage_pipe #(.IMEM_DEPTH(256), .PC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken), .br_target(br_target),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .pc(pc), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr), .id_valid(id_valid),
    .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_id(input string tag, input logic [31:0] instr, input logic [31:0] p4,
                          input logic v, input logic [31:0] cnt, input logic [31:0] npc);
    check({tag, ".instr"}, id_instr, instr);
    check({tag, ".pc_plus4"}, id_pc_plus4, p4);
    check({tag, ".valid"}, {31'h0, id_valid}, {31'h0, v});
    check({tag, ".count"}, fetch_count, cnt);
    check({tag, ".pc"}, pc, npc);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) em[i] = (i < 4) ? 32'h11 * (i + 1) : 32'hC000_0000 + i;
    rst = 1'b1; freeze = 1'b1; br_taken = 1'b1; br_target = 32'h40;
    tick();
    tick();
    check_id("t1_reset", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0; br_taken = 1'b0;
    for (int i = 0; i < 16; i++) begin
      imem_we = 1'b1; imem_waddr = 8'(i); imem_wdata = em[i];
      tick();
    end
    imem_we = 1'b0;
    check_id("load_frozen", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    freeze = 1'b0;
    tick();
    check_id("t2_f0", 32'h11, 32'h4, 1'b1, 32'd1, 32'h4);
    tick();
    check_id("t2_f1", 32'h22, 32'h8, 1'b1, 32'd2, 32'h8);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_id("t3_hold", 32'h22, 32'h8, 1'b1, 32'd2, 32'h8);
    end
    freeze = 1'b0;
    tick();
    check_id("t3_rel", 32'h33, 32'hC, 1'b1, 32'd3, 32'hC);
    tick();
    check_id("t2_f3", 32'h44, 32'h10, 1'b1, 32'd4, 32'h10);
    br_taken = 1'b1; freeze = 1'b1; br_target = 32'h20;
    tick();
    check_id("t4_flush", 32'h0, 32'h0, 1'b0, 32'd4, 32'h20);
    br_taken = 1'b0; freeze = 1'b0;
    tick();
    check_id("t4_target", em[8], 32'h24, 1'b1, 32'd5, 32'h24);
    br_taken = 1'b1; br_target = 32'h400;
    tick();
    check_id("t5_br_oor", 32'h0, 32'h0, 1'b0, 32'd5, 32'h400);
    br_taken = 1'b0;
    tick();
    check_id("t5_oor", 32'h0, 32'h404, 1'b1, 32'd6, 32'h404);
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    tick();
    br_taken = 1'b0;
    tick();
    check_id("t5_wrap", 32'h0, 32'h0, 1'b1, 32'd7, 32'h0);
    tick();
    check_id("t5_after_wrap", 32'h11, 32'h4, 1'b1, 32'd8, 32'h4);
    imem_we = 1'b1; imem_waddr = 8'd1; imem_wdata = 32'hAA;
    tick();
    imem_we = 1'b0;
    check_id("t6_collide_old", 32'h22, 32'h8, 1'b1, 32'd9, 32'h8);
    br_taken = 1'b1; br_target = 32'h4;
    tick();
    br_taken = 1'b0;
    tick();
    check_id("t6_new_word", 32'hAA, 32'h8, 1'b1, 32'd10, 32'h8);
    tick();
    tick();
    rst = 1'b1; imem_we = 1'b1; imem_waddr = 8'd2; imem_wdata = 32'hDEAD;
    tick();
    check_id("t6_midrst", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0; imem_we = 1'b0;
    tick();
    check_id("t6_r0", 32'h11, 32'h4, 1'b1, 32'd1, 32'h4);
    tick();
    check_id("t6_r1", 32'hAA, 32'h8, 1'b1, 32'd2, 32'h8);
    tick();
    check_id("t6_r2_wr_ignored", 32'h33, 32'hC, 1'b1, 32'd3, 32'hC);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
